// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared types, encodings and helpers for the multicycle control unit
package cu_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_FAULT  = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      CL_NOP, CL_ADD, CL_SUB, CL_AND, CL_ORR,
      CL_ADDI, CL_SUBI, CL_ANDI, CL_ORRI,
      CL_LDUR, CL_STUR, CL_B, CL_CBZ, CL_CBNZ
   } op_class_e;

   // Decode looks only at the top PAT_W opcode bits.
   localparam int PAT_W = 11;

   localparam logic [10:0] PAT_ADD  = 11'b10001011000;
   localparam logic [10:0] PAT_SUB  = 11'b11001011000;
   localparam logic [10:0] PAT_AND  = 11'b10001010000;
   localparam logic [10:0] PAT_ORR  = 11'b10101010000;
   localparam logic [10:0] PAT_ADDI = 11'b10010001000;
   localparam logic [10:0] PAT_SUBI = 11'b11010001000;
   localparam logic [10:0] PAT_ANDI = 11'b10010010000;
   localparam logic [10:0] PAT_ORRI = 11'b10110010000;
   localparam logic [10:0] PAT_LDUR = 11'b11111000010;
   localparam logic [10:0] PAT_STUR = 11'b11111000000;
   localparam logic [10:0] PAT_B    = 11'b00010100000;
   localparam logic [10:0] PAT_CBZ  = 11'b10110100000;
   localparam logic [10:0] PAT_CBNZ = 11'b10110101000;

   // Mask bits set to 1 are compared; 0 bits are don't-care.
   localparam logic [10:0] MASK_FULL = 11'b11111111111;
   localparam logic [10:0] MASK_I    = 11'b11111111110;
   localparam logic [10:0] MASK_B    = 11'b11111100000;
   localparam logic [10:0] MASK_CB   = 11'b11111111000;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_ORR   = 3'b011;
   localparam logic [2:0] ALU_PASSB = 3'b100;

   localparam logic [1:0] SEU_IMM = 2'b00;
   localparam logic [1:0] SEU_D   = 2'b01;
   localparam logic [1:0] SEU_B   = 2'b10;
   localparam logic [1:0] SEU_CB  = 2'b11;

   function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat,
                                     input logic [10:0] mask);
      return (op & mask) == (pat & mask);
   endfunction

   function automatic logic is_rtype(input op_class_e c);
      return (c == CL_ADD) || (c == CL_SUB) || (c == CL_AND) || (c == CL_ORR);
   endfunction

   function automatic logic is_itype(input op_class_e c);
      return (c == CL_ADDI) || (c == CL_SUBI) || (c == CL_ANDI) || (c == CL_ORRI);
   endfunction

   function automatic logic [2:0] alu_op_of(input op_class_e c);
      logic [2:0] r;
      r = ALU_ADD;
      if ((c == CL_SUB) || (c == CL_SUBI)) r = ALU_SUB;
      if ((c == CL_AND) || (c == CL_ANDI)) r = ALU_AND;
      if ((c == CL_ORR) || (c == CL_ORRI)) r = ALU_ORR;
      return r;
   endfunction

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational opcode to instruction-class decoder
module cu_decode
   import cu_pkg::*;
#(
   parameter int OPCODE_W = 11
) (
   input  logic [OPCODE_W-1:0] opcode_i,
   output op_class_e           cls_o
);

   logic [PAT_W-1:0] top_bits;
   assign top_bits = opcode_i[OPCODE_W-1 -: PAT_W];

   // Patterns are disjoint; anything unmatched is treated as a NOP.
   always_comb begin
      cls_o = CL_NOP;
      if      (op_match(top_bits, PAT_ADD,  MASK_FULL)) cls_o = CL_ADD;
      else if (op_match(top_bits, PAT_SUB,  MASK_FULL)) cls_o = CL_SUB;
      else if (op_match(top_bits, PAT_AND,  MASK_FULL)) cls_o = CL_AND;
      else if (op_match(top_bits, PAT_ORR,  MASK_FULL)) cls_o = CL_ORR;
      else if (op_match(top_bits, PAT_ADDI, MASK_I))    cls_o = CL_ADDI;
      else if (op_match(top_bits, PAT_SUBI, MASK_I))    cls_o = CL_SUBI;
      else if (op_match(top_bits, PAT_ANDI, MASK_I))    cls_o = CL_ANDI;
      else if (op_match(top_bits, PAT_ORRI, MASK_I))    cls_o = CL_ORRI;
      else if (op_match(top_bits, PAT_LDUR, MASK_FULL)) cls_o = CL_LDUR;
      else if (op_match(top_bits, PAT_STUR, MASK_FULL)) cls_o = CL_STUR;
      else if (op_match(top_bits, PAT_B,    MASK_B))    cls_o = CL_B;
      else if (op_match(top_bits, PAT_CBZ,  MASK_CB))   cls_o = CL_CBZ;
      else if (op_match(top_bits, PAT_CBNZ, MASK_CB))   cls_o = CL_CBNZ;
   end

endmodule

// File: rtl/multicycle_cu.sv
// rtl/multicycle_cu.sv - multicycle control FSM with memory-wait timeout
module multicycle_cu
   import cu_pkg::*;
#(
   parameter int OPCODE_W = 11,
   parameter int ALUOP_W  = 3,
   parameter int TIMEOUT  = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                bus_reg2loc,
   output logic                bus_aluSrc,
   output logic                bus_memToReg,
   output logic                bus_regWr,
   output logic                bus_pcSrc,
   output logic [1:0]          bus_seu,
   output logic [ALUOP_W-1:0]  bus_aluOp,
   output logic                bus_memRd,
   output logic                bus_memWr,
   output logic                bus_irWr,
   output logic                bus_pcWr,
   output logic [2:0]          state,
   output logic                fault
);

   // 9-bit compare so wait_q + 1 cannot wrap for TIMEOUT up to 255.
   localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

   state_e    state_q, state_d;
   op_class_e class_q, class_d;
   op_class_e dec_cls;
   logic [7:0] wait_q, wait_d;
   logic       timeout_hit;

   cu_decode #(.OPCODE_W(OPCODE_W)) u_decode (
      .opcode_i (opcode),
      .cls_o    (dec_cls)
   );

   assign timeout_hit = ({1'b0, wait_q} + 9'd1) >= TO_LIM;
   assign state       = state_q;
   assign fault       = (state_q == ST_FAULT);

   // Class is captured on the edge where the instruction register loads.
   assign class_d = (state_q == ST_FETCH && mem_ready) ? dec_cls : class_q;

   // State, wait counter and latched class registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         wait_q  <= '0;
         class_q <= CL_NOP;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         class_q <= class_d;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_d      = state_q;
      wait_d       = '0;
      bus_reg2loc  = 1'b0;
      bus_aluSrc   = 1'b0;
      bus_memToReg = 1'b0;
      bus_regWr    = 1'b0;
      bus_pcSrc    = 1'b0;
      bus_seu      = SEU_IMM;
      bus_aluOp    = '0;
      bus_memRd    = 1'b0;
      bus_memWr    = 1'b0;
      bus_irWr     = 1'b0;
      bus_pcWr     = 1'b0;
      case (state_q)
         ST_FETCH: begin
            bus_memRd = 1'b1;
            if (mem_ready) begin
               bus_irWr = 1'b1;
               state_d  = ST_DECODE;
            end else if (timeout_hit) begin
               state_d = ST_FAULT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         ST_DECODE: begin
            if (class_q == CL_NOP) begin
               bus_pcWr = 1'b1;
               state_d  = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (is_rtype(class_q)) begin
               bus_aluOp = ALUOP_W'(alu_op_of(class_q));
               state_d   = ST_WB;
            end else if (is_itype(class_q)) begin
               bus_aluSrc = 1'b1;
               bus_seu    = SEU_IMM;
               bus_aluOp  = ALUOP_W'(alu_op_of(class_q));
               state_d    = ST_WB;
            end else if (class_q == CL_LDUR || class_q == CL_STUR) begin
               bus_aluSrc  = 1'b1;
               bus_seu     = SEU_D;
               bus_aluOp   = ALUOP_W'(ALU_ADD);
               bus_reg2loc = (class_q == CL_STUR);
               state_d     = ST_MEM;
            end else if (class_q == CL_B) begin
               bus_seu   = SEU_B;
               bus_pcSrc = 1'b1;
               bus_pcWr  = 1'b1;
               state_d   = ST_FETCH;
            end else if (class_q == CL_CBZ || class_q == CL_CBNZ) begin
               bus_reg2loc = 1'b1;
               bus_seu     = SEU_CB;
               bus_aluOp   = ALUOP_W'(ALU_PASSB);
               bus_pcWr    = 1'b1;
               bus_pcSrc   = (class_q == CL_CBZ) ? zero : !zero;
               state_d     = ST_FETCH;
            end else begin
               // NOP never reaches EXEC; still retire it with a single PC step.
               bus_pcWr = 1'b1;
               state_d  = ST_FETCH;
            end
         end
         ST_MEM: begin
            bus_memRd = (class_q == CL_LDUR);
            bus_memWr = (class_q != CL_LDUR);
            if (mem_ready) begin
               if (class_q == CL_LDUR) begin
                  state_d = ST_WB;
               end else begin
                  bus_pcWr = 1'b1;
                  state_d  = ST_FETCH;
               end
            end else if (timeout_hit) begin
               state_d = ST_FAULT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         ST_WB: begin
            bus_regWr    = 1'b1;
            bus_memToReg = (class_q == CL_LDUR);
            bus_pcWr     = 1'b1;
            state_d      = ST_FETCH;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_cu.sv
// tb/tb_multicycle_cu.sv - table-driven self-checking bench for multicycle_cu
module tb_multicycle_cu;

   localparam logic [14:0] F   = 15'(1 << 0);
   localparam logic [14:0] PW  = 15'(1 << 1);
   localparam logic [14:0] IR  = 15'(1 << 2);
   localparam logic [14:0] MW  = 15'(1 << 3);
   localparam logic [14:0] MR  = 15'(1 << 4);
   localparam logic [14:0] PS  = 15'(1 << 10);
   localparam logic [14:0] RW  = 15'(1 << 11);
   localparam logic [14:0] M2R = 15'(1 << 12);
   localparam logic [14:0] AS  = 15'(1 << 13);
   localparam logic [14:0] R2L = 15'(1 << 14);

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_ADDI = 11'b10010001001;
   localparam logic [10:0] OP_SUBI = 11'b11010001000;
   localparam logic [10:0] OP_ANDI = 11'b10010010001;
   localparam logic [10:0] OP_ORRI = 11'b10110010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_B    = 11'b00010110101;
   localparam logic [10:0] OP_CBZ  = 11'b10110100101;
   localparam logic [10:0] OP_CBNZ = 11'b10110101011;
   localparam logic [10:0] OP_NOP  = 11'b11111111111;
   localparam logic [10:0] OP_JUNK = 11'b00000000000;

   typedef struct {
      logic        rst_n;
      logic [10:0] op;
      logic        zero;
      logic        rdy;
      logic [2:0]  st;
      logic [14:0] outs;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [10:0] opcode;
   logic        zero;
   logic        mem_ready;
   logic        bus_reg2loc, bus_aluSrc, bus_memToReg, bus_regWr, bus_pcSrc;
   logic [1:0]  bus_seu;
   logic [2:0]  bus_aluOp;
   logic        bus_memRd, bus_memWr, bus_irWr, bus_pcWr;
   logic [2:0]  state;
   logic        fault;

   int   checks;
   int   errors;
   vec_t vecs[$];

   multicycle_cu #(.OPCODE_W(11), .ALUOP_W(3), .TIMEOUT(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode       (opcode),
      .zero         (zero),
      .mem_ready    (mem_ready),
      .bus_reg2loc  (bus_reg2loc),
      .bus_aluSrc   (bus_aluSrc),
      .bus_memToReg (bus_memToReg),
      .bus_regWr    (bus_regWr),
      .bus_pcSrc    (bus_pcSrc),
      .bus_seu      (bus_seu),
      .bus_aluOp    (bus_aluOp),
      .bus_memRd    (bus_memRd),
      .bus_memWr    (bus_memWr),
      .bus_irWr     (bus_irWr),
      .bus_pcWr     (bus_pcWr),
      .state        (state),
      .fault        (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] aop(input int v);
      return 15'(v << 5);
   endfunction

   function automatic logic [14:0] seu(input int v);
      return 15'(v << 8);
   endfunction

   function automatic logic [14:0] dut_outs();
      return {bus_reg2loc, bus_aluSrc, bus_memToReg, bus_regWr, bus_pcSrc, bus_seu,
              bus_aluOp, bus_memRd, bus_memWr, bus_irWr, bus_pcWr, fault};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [10:0] op, input logic z, input logic rdy,
                      input logic [2:0] st, input logic [14:0] o);
      vec_t v;
      v.rst_n = r; v.op = op; v.zero = z; v.rdy = rdy; v.st = st; v.outs = o;
      vecs.push_back(v);
   endtask

   // Fetch and decode with the opcode held, then EXEC with a junk opcode driven.
   task automatic fetch_decode(input logic [10:0] op);
      add(1'b1, op, 1'b0, 1'b1, 3'd0, MR | IR);
      add(1'b1, op, 1'b0, 1'b1, 3'd1, 15'd0);
   endtask

   task automatic alu_instr(input logic [10:0] op, input logic [14:0] exec_outs);
      fetch_decode(op);
      add(1'b1, OP_JUNK, 1'b1, 1'b1, 3'd2, exec_outs);
      add(1'b1, OP_JUNK, 1'b1, 1'b1, 3'd4, RW | PW);
   endtask

   task automatic branch_instr(input logic [10:0] op, input logic z, input logic [14:0] exec_outs);
      fetch_decode(op);
      add(1'b1, OP_JUNK, z, 1'b1, 3'd2, exec_outs);
   endtask

   task automatic build_table();
      alu_instr(OP_ADD,  aop(0));
      alu_instr(OP_SUB,  aop(1));
      alu_instr(OP_AND,  aop(2));
      alu_instr(OP_ORR,  aop(3));
      alu_instr(OP_ADDI, AS | seu(0) | aop(0));
      alu_instr(OP_SUBI, AS | seu(0) | aop(1));
      alu_instr(OP_ANDI, AS | seu(0) | aop(2));
      alu_instr(OP_ORRI, AS | seu(0) | aop(3));
      // LDUR with three wait cycles in MEM
      fetch_decode(OP_LDUR);
      add(1'b1, OP_JUNK, 1'b0, 1'b1, 3'd2, AS | seu(1));
      for (int i = 0; i < 3; i++) add(1'b1, OP_JUNK, 1'b0, 1'b0, 3'd3, MR);
      add(1'b1, OP_JUNK, 1'b0, 1'b1, 3'd3, MR);
      add(1'b1, OP_JUNK, 1'b0, 1'b1, 3'd4, RW | M2R | PW);
      // STUR with immediate acknowledge
      fetch_decode(OP_STUR);
      add(1'b1, OP_JUNK, 1'b0, 1'b1, 3'd2, AS | seu(1) | R2L);
      add(1'b1, OP_JUNK, 1'b0, 1'b1, 3'd3, MW | PW);
      // Conditional and unconditional branches
      branch_instr(OP_CBZ,  1'b1, R2L | seu(3) | aop(4) | PW | PS);
      branch_instr(OP_CBZ,  1'b0, R2L | seu(3) | aop(4) | PW);
      branch_instr(OP_CBNZ, 1'b1, R2L | seu(3) | aop(4) | PW);
      branch_instr(OP_CBNZ, 1'b0, R2L | seu(3) | aop(4) | PW | PS);
      branch_instr(OP_B,    1'b1, seu(2) | PW | PS);
      branch_instr(OP_B,    1'b0, seu(2) | PW | PS);
      // Unrecognised opcodes retire from DECODE
      add(1'b1, OP_NOP, 1'b0, 1'b1, 3'd0, MR | IR);
      add(1'b1, OP_NOP, 1'b0, 1'b1, 3'd1, PW);
      add(1'b1, OP_JUNK, 1'b0, 1'b1, 3'd0, MR | IR);
      add(1'b1, OP_JUNK, 1'b0, 1'b1, 3'd1, PW);
      // Ready arrives on the last allowed wait cycle: no fault
      for (int i = 0; i < 3; i++) add(1'b1, OP_NOP, 1'b0, 1'b0, 3'd0, MR);
      add(1'b1, OP_NOP, 1'b0, 1'b1, 3'd0, MR | IR);
      add(1'b1, OP_NOP, 1'b0, 1'b1, 3'd1, PW);
      // FETCH timeout: four wait cycles then FAULT, held until reset
      for (int i = 0; i < 4; i++) add(1'b1, OP_ADD, 1'b0, 1'b0, 3'd0, MR);
      add(1'b1, OP_ADD, 1'b0, 1'b1, 3'd5, F);
      add(1'b1, OP_ADD, 1'b0, 1'b1, 3'd5, F);
      add(1'b0, OP_ADD, 1'b0, 1'b0, 3'd0, MR);
      // MEM timeout for a store: counter restarts on MEM entry
      add(1'b1, OP_STUR, 1'b0, 1'b0, 3'd0, MR);
      add(1'b1, OP_STUR, 1'b0, 1'b1, 3'd0, MR | IR);
      add(1'b1, OP_STUR, 1'b0, 1'b0, 3'd1, 15'd0);
      add(1'b1, OP_STUR, 1'b0, 1'b0, 3'd2, AS | seu(1) | R2L);
      for (int i = 0; i < 4; i++) add(1'b1, OP_STUR, 1'b0, 1'b0, 3'd3, MW);
      add(1'b1, OP_STUR, 1'b0, 1'b0, 3'd5, F);
      add(1'b0, OP_ADD, 1'b0, 1'b1, 3'd0, MR | IR);
      add(1'b1, OP_ADD, 1'b0, 1'b1, 3'd0, MR | IR);
      add(1'b1, OP_ADD, 1'b0, 1'b1, 3'd1, 15'd0);
      add(1'b1, OP_ADD, 1'b0, 1'b1, 3'd2, aop(0));
      add(1'b1, OP_ADD, 1'b0, 1'b1, 3'd4, RW | PW);
   endtask

   task automatic drive(input logic r, input logic [10:0] op, input logic z, input logic rdy);
      @(negedge clk);
      rst_n = r; opcode = op; zero = z; mem_ready = rdy;
      #2;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0; opcode = OP_JUNK; zero = 1'b0; mem_ready = 1'b0;
      #2;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_fault", 32'(fault), 32'd0);

      build_table();
      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].op, vecs[i].zero, vecs[i].rdy);
         chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
         chk($sformatf("vec%0d_outs", i), 32'(dut_outs()), 32'(vecs[i].outs));
      end

      // Asynchronous reset in the middle of a stalled store
      drive(1'b1, OP_STUR, 1'b0, 1'b1);
      chk("stur_fetch", 32'(state), 32'd0);
      drive(1'b1, OP_STUR, 1'b0, 1'b0);
      drive(1'b1, OP_JUNK, 1'b0, 1'b0);
      drive(1'b1, OP_JUNK, 1'b0, 1'b0);
      chk("stur_mem_state", 32'(state), 32'd3);
      chk("stur_mem_wr", 32'(bus_memWr), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_memwr", 32'(bus_memWr), 32'd0);
      chk("async_rst_fault", 32'(fault), 32'd0);
      chk("async_rst_pcwr_regwr", 32'({bus_pcWr, bus_regWr}), 32'd0);
      drive(1'b1, OP_ADD, 1'b0, 1'b1);
      chk("post_rst_outs", 32'(dut_outs()), 32'(MR | IR));
      drive(1'b1, OP_ADD, 1'b0, 1'b1);
      chk("post_rst_decode", 32'(state), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_cu.md
MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 Parameter OPCODE_W, 11, opcode field width; decode patterns match the top 11 bits.
REQ-002 Parameter ALUOP_W, 3, ALU operation code width.
REQ-003 Parameter TIMEOUT, 15, maximum cycles spent waiting on mem_ready before fault (range 1..255).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 opcode  input  OPCODE_W  instruction opcode field, valid when bus_irWr pulses (captured at the DECODE edge).
REQ-007 zero  input  1  ALU zero flag, sampled in EXEC.
REQ-008 mem_ready  input  1  memory handshake acknowledge for FETCH and MEM accesses.
REQ-009 bus_reg2loc, bus_aluSrc, bus_memToReg, bus_regWr, bus_pcSrc  output  1 each  datapath controls, same meaning as the single-cycle unit.
REQ-010 bus_seu  output  2  immediate select: 00 ALU-imm, 01 D-type, 10 B, 11 CB.
REQ-011 bus_aluOp  output  ALUOP_W  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 pass-B.
REQ-012 bus_memRd, bus_memWr  output  1 each  memory request strobes.
REQ-013 bus_irWr, bus_pcWr  output  1 each  instruction-register load, PC update.
REQ-014 state  output  3  current FSM state; fault  output  1  timeout flag.

Function
REQ-015 States SHALL be FETCH, DECODE, EXEC, MEM, WB, FAULT; outputs are Moore-decoded from state and latched opcode class, except bus_pcSrc in EXEC, which depends on zero.
REQ-016 FETCH: bus_memRd=1; while mem_ready=0 remain; on mem_ready=1 pulse bus_irWr=1 that cycle, next DECODE.
REQ-017 DECODE: latch opcode class (ADD, SUB, AND, ORR, ADDI, SUBI, ANDI, ORRI, LDUR, STUR, B, CBZ, CBNZ, NOP); unrecognised opcode = NOP; NOP goes to FETCH with bus_pcWr=1, bus_pcSrc=0; all others go to EXEC.
REQ-018 Later states SHALL use only the latched class; opcode changes after DECODE have no effect.
REQ-019 EXEC R-type: aluSrc=0, reg2loc=0, aluOp per REQ-011; I-type: aluSrc=1, seu=00; both next WB.
REQ-020 EXEC LDUR/STUR: aluSrc=1, seu=01, aluOp=000, STUR reg2loc=1; next MEM.
REQ-021 EXEC B: seu=10, pcSrc=1 unconditionally, pcWr=1; next FETCH.
REQ-022 EXEC CBZ/CBNZ: reg2loc=1, seu=11, aluOp=100, pcWr=1, pcSrc=zero (CBZ) or !zero (CBNZ); next FETCH.
REQ-023 MEM: LDUR holds bus_memRd=1, STUR holds bus_memWr=1 until mem_ready=1; then LDUR next WB, STUR next FETCH with pcWr=1.
REQ-024 WB: regWr=1, memToReg=1 for LDUR else 0, pcWr=1, pcSrc=0; next FETCH.
REQ-025 Outputs not listed for a state SHALL be 0; bus_memRd and bus_memWr never both 1; bus_pcWr exactly one cycle per instruction.
REQ-026 Wait counter (8 bits) clears on entry to FETCH/MEM, increments each cycle mem_ready=0 there; on reaching TIMEOUT with mem_ready still 0, next state FAULT.
REQ-027 mem_ready=1 in the same cycle the counter reaches TIMEOUT SHALL win (normal transition, no fault).
REQ-028 FAULT: fault=1, all bus_* outputs 0, held until reset.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=FETCH, wait counter=0, latched class=NOP, fault=0, regardless of current state.
REQ-030 After rst_n deasserts, first rising edge evaluates FETCH with bus_memRd=1; mid-instruction reset discards the instruction with no pcWr/regWr/memWr issued.

Structure
REQ-031 Package cu_pkg SHALL hold state encoding, opcode patterns, aluOp and seu constants, and the opcode-class enumeration.
REQ-032 Combinational sub-module cu_decode SHALL map opcode to class; multicycle_cu instantiates it once.

Verification
REQ-033 ADD (10001011000), mem_ready=1 always -> FETCH,DECODE,EXEC,WB; aluOp=000 in EXEC; regWr=1, pcWr=1 in WB; 4 cycles.
REQ-034 LDUR (11111000010), mem_ready low 3 cycles in MEM -> memRd held 4 cycles; WB memToReg=1, regWr=1; no fault.
REQ-035 CBZ (10110100xxx) zero=1 -> EXEC pcSrc=1, pcWr=1; repeat with zero=0 -> pcSrc=0; CBNZ inverse.
REQ-036 B (000101xxxxx) zero=1 -> pcSrc=1; opcode 11111111111 -> NOP, DECODE pcWr=1, regWr never 1.
REQ-037 TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 4 wait cycles, fault=1; mem_ready=1 on the 4th cycle -> DECODE, no fault.
REQ-038 rst_n pulsed low during MEM of STUR -> state=FETCH immediately, memWr drops asynchronously, fault=0.
